clock_tap_tracker: RTL

//  Closed-loop controller for the phi0 delay-line tap: consumes the phase samples produced by

---
 rtl/clock_tap_tracker.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/clock_tap_tracker.sv
// clock_tap_tracker
// Closed-loop controller for the phi0 delay-line tap. Averages phase samples
// from clock_difference, steps the tap by +/-1 toward TARGET, and reports
// lock status. Manual up/down pulses override the loop at any time.
module clock_tap_tracker #(
  parameter int TAP_W       = 9,
  parameter int TAP_INITIAL = 50,
  parameter int TAP_MIN     = 0,
  parameter int TAP_MAX     = 499,
  parameter int TARGET      = 0,
  parameter int DEADBAND    = 2,
  parameter int AVG_LOG2    = 3,
  parameter int HOLDOFF     = 4,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             eclk,
  input  logic             ereset,
  input  logic             auto_en,
  input  logic             diff_valid,
  input  logic [15:0]      diffticks,
  input  logic             man_up,
  input  logic             man_dn,
  output logic [TAP_W-1:0] tap,
  output logic             locked,
  output logic             tap_step,
  output logic [15:0]      avg_err
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  localparam logic [CNT_W-1:0]  CNT_LAST_C = CNT_W'(2**AVG_LOG2 - 1);
  localparam logic [TAP_W-1:0]  TAP_INIT_C = TAP_W'(TAP_INITIAL);
  localparam logic [TAP_W-1:0]  TAP_MIN_C  = TAP_W'(TAP_MIN);
  localparam logic [TAP_W-1:0]  TAP_MAX_C  = TAP_W'(TAP_MAX);
  localparam logic [TAP_W-1:0]  TAP_ONE_C  = TAP_W'(1);
  localparam logic signed [16:0] TARGET_C  = 17'(TARGET);
  localparam logic signed [16:0] DB_POS_C  = 17'(DEADBAND);
  localparam logic signed [16:0] DB_NEG_C  = 17'(-DEADBAND);
  localparam logic [7:0]        HOLD_C     = 8'(HOLDOFF);
  localparam logic [7:0]        RUN_MAX_C  = 8'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EVAL  = 2'd2
  } state_t;

  // Saturate a 17-bit signed error to the 16-bit display range.
  function automatic logic [15:0] sat16(input logic signed [16:0] v);
    logic [15:0] r;
    if (v[16] != v[15]) begin
      r = v[16] ? 16'h8000 : 16'h7fff;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  state_t                   state_r,    state_s;
  logic [7:0]               hold_r,     hold_s;
  logic signed [ACC_W-1:0]  acc_r,      acc_s;
  logic [CNT_W-1:0]         cnt_r,      cnt_s;
  logic [7:0]               run_r,      run_s;
  logic [TAP_W-1:0]         tap_r,      tap_s;
  logic                     locked_r,   locked_s;
  logic                     tap_step_r, tap_step_s;
  logic [15:0]              avg_err_r,  avg_err_s;

  logic [ACC_W-1:0]         sample_ext_s;
  logic [15:0]              avg_s;
  logic signed [16:0]       err_s;
  logic                     want_up_s;
  logic                     want_dn_s;
  logic                     on_target_s;
  logic                     can_up_s;
  logic                     can_dn_s;

  // Datapath: sign-extended sample, floor average (arithmetic shift) and error.
  assign sample_ext_s = {{AVG_LOG2{diffticks[15]}}, diffticks};
  assign avg_s        = acc_r[AVG_LOG2 +: 16];
  assign err_s        = $signed({avg_s[15], avg_s}) - TARGET_C;
  assign want_up_s    = (err_s > DB_POS_C);
  assign want_dn_s    = (err_s < DB_NEG_C);
  assign on_target_s  = !want_up_s && !want_dn_s;
  assign can_up_s     = (tap_r < TAP_MAX_C);
  assign can_dn_s     = (tap_r > TAP_MIN_C);

  // Next-state and output logic: loop FSM first, manual pulses override last.
  always_comb begin
    state_s    = state_r;
    hold_s     = hold_r;
    acc_s      = acc_r;
    cnt_s      = cnt_r;
    run_s      = run_r;
    tap_s      = tap_r;
    locked_s   = locked_r;
    tap_step_s = 1'b0;
    avg_err_s  = avg_err_r;

    case (state_r)
      ST_HOLD: begin
        if (hold_r == 8'd0) begin
          state_s = ST_ACCUM;
          acc_s   = '0;
          cnt_s   = '0;
        end else if (diff_valid) begin
          hold_s = hold_r - 8'd1;
          if (hold_r == 8'd1) begin
            state_s = ST_ACCUM;
            acc_s   = '0;
            cnt_s   = '0;
          end else begin
            state_s = ST_HOLD;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end

      ST_ACCUM: begin
        if (diff_valid) begin
          acc_s = acc_r + $signed(sample_ext_s);
          cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_LAST_C) begin
            state_s = ST_EVAL;
          end else begin
            state_s = ST_ACCUM;
          end
        end else begin
          state_s = ST_ACCUM;
        end
      end

      ST_EVAL: begin
        avg_err_s = sat16(err_s);
        acc_s     = '0;
        cnt_s     = '0;
        if (auto_en && ((want_up_s && can_up_s) || (want_dn_s && can_dn_s))) begin
          // A step invalidates the running average; wait for the line to settle.
          tap_s      = want_up_s ? (tap_r + TAP_ONE_C) : (tap_r - TAP_ONE_C);
          tap_step_s = 1'b1;
          run_s      = 8'd0;
          locked_s   = 1'b0;
          hold_s     = HOLD_C;
          state_s    = ST_HOLD;
        end else if (on_target_s) begin
          run_s    = (run_r < RUN_MAX_C) ? (run_r + 8'd1) : run_r;
          locked_s = auto_en && (run_s >= RUN_MAX_C);
          state_s  = ST_ACCUM;
        end else begin
          // Off target but unable to step (bound or loop disabled).
          run_s    = 8'd0;
          locked_s = 1'b0;
          state_s  = ST_ACCUM;
        end
      end

      default: begin
        state_s = ST_HOLD;
        hold_s  = HOLD_C;
        acc_s   = '0;
        cnt_s   = '0;
      end
    endcase

    // Manual override: exactly one of up/down restarts the loop from HOLD.
    case ({man_up, man_dn})
      2'b10: begin
        if (can_up_s) begin
          tap_s      = tap_r + TAP_ONE_C;
          tap_step_s = 1'b1;
        end else begin
          tap_s      = tap_r;
          tap_step_s = 1'b0;
        end
        locked_s = 1'b0;
        run_s    = 8'd0;
        state_s  = ST_HOLD;
        hold_s   = HOLD_C;
        acc_s    = '0;
        cnt_s    = '0;
      end
      2'b01: begin
        if (can_dn_s) begin
          tap_s      = tap_r - TAP_ONE_C;
          tap_step_s = 1'b1;
        end else begin
          tap_s      = tap_r;
          tap_step_s = 1'b0;
        end
        locked_s = 1'b0;
        run_s    = 8'd0;
        state_s  = ST_HOLD;
        hold_s   = HOLD_C;
        acc_s    = '0;
        cnt_s    = '0;
      end
      default: begin
        locked_s = locked_s;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge eclk) begin
    if (ereset) begin
      state_r    <= ST_HOLD;
      hold_r     <= HOLD_C;
      acc_r      <= '0;
      cnt_r      <= '0;
      run_r      <= 8'd0;
      tap_r      <= TAP_INIT_C;
      locked_r   <= 1'b0;
      tap_step_r <= 1'b0;
      avg_err_r  <= 16'd0;
    end else begin
      state_r    <= state_s;
      hold_r     <= hold_s;
      acc_r      <= acc_s;
      cnt_r      <= cnt_s;
      run_r      <= run_s;
      tap_r      <= tap_s;
      locked_r   <= locked_s;
      tap_step_r <= tap_step_s;
      avg_err_r  <= avg_err_s;
    end
  end

  assign tap      = tap_r;
  assign locked   = locked_r;
  assign tap_step = tap_step_r;
  assign avg_err  = avg_err_r;

endmodule
